// File: rtl/l1_cache_pkg.sv
// Shared L1 cache definitions: L2 command codes, refill FSM states and a
// constant-expression clog2 helper for deriving field widths.
package l1_cache_pkg;

    localparam logic [1:0] L2_CMD_RD = 2'b00;
    localparam logic [1:0] L2_CMD_WR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_FILL = 3'd2,
        ST_TAG  = 3'd3,
        ST_ERR  = 3'd4
    } refill_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = 32'(i + 1);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/l1_beat_counter.sv
// Wrapping beat counter with synchronous clear and a terminal-count flag;
// clear has priority over increment.
module l1_beat_counter
    import l1_cache_pkg::*;
#(
    parameter int unsigned COUNT = 8,
    parameter int unsigned CNT_W = clog2(COUNT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_last_c
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= o_last_c ? '0 : r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt    = r_cnt;
    assign o_last_c = (r_cnt == CNT_W'(COUNT - 1));

endmodule

// File: rtl/l1_refill_engine.sv
// L1 miss refill engine: accepts one miss, issues a burst read to L2, streams
// the beats into the data RAM and then installs the tag (or aborts on error).
module l1_refill_engine
    import l1_cache_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE     = 32,
    parameter int unsigned L2_CMND_WIDTH  = 2,
    parameter int unsigned L2_SIZE_WIDTH  = 3,
    parameter int unsigned L2_ADDR_WIDTH  = 16,
    parameter int unsigned L2_DATA_WIDTH  = 32,
    localparam int unsigned OFF_W          = clog2(BLOCK_SIZE),
    localparam int unsigned LINE_IDX_WIDTH = L2_ADDR_WIDTH - OFF_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      miss_val,
    input  logic [L2_ADDR_WIDTH-1:0]  miss_addr,
    output logic                      miss_ack,
    output logic                      refill_done,
    output logic                      refill_err,
    output logic                      req_val,
    input  logic                      req_ack,
    output logic                      req_nc,
    output logic [L2_CMND_WIDTH-1:0]  req_cmd,
    output logic [L2_SIZE_WIDTH-1:0]  req_size,
    output logic [L2_ADDR_WIDTH-1:0]  req_addr,
    input  logic                      resp_rdata_val,
    input  logic [L2_DATA_WIDTH-1:0]  resp_rdata,
    input  logic                      resp_val,
    input  logic                      resp_err,
    output logic                      ram_wen,
    output logic [L2_ADDR_WIDTH-3:0]  ram_waddr,
    output logic [L2_DATA_WIDTH-1:0]  ram_wdata,
    output logic                      tag_wr_val,
    output logic [LINE_IDX_WIDTH-1:0] tag_wr_addr,
    output logic [LINE_IDX_WIDTH-1:0] tag_wr_data
);

    localparam int unsigned BEATS = BLOCK_SIZE * 8 / L2_DATA_WIDTH;
    localparam int unsigned CNT_W = clog2(BEATS);

    refill_state_e             r_state;
    refill_state_e             w_next;
    logic [LINE_IDX_WIDTH-1:0] r_line;
    logic [CNT_W-1:0]          w_cnt;
    logic                      w_last;
    logic                      w_accept;
    logic                      w_beat;
    logic                      w_end_ok;
    logic                      w_end_err;
    logic                      w_unused_offset;

    // Accept is gated by rst_n so the handshake stays low while reset is held.
    assign w_accept  = rst_n && (r_state == ST_IDLE) && miss_val;
    assign w_beat    = (r_state == ST_FILL) && resp_rdata_val;
    assign w_end_ok  = w_beat && resp_val && !resp_err && w_last;
    assign w_end_err = (r_state == ST_FILL) && resp_val && !w_end_ok;

    assign w_unused_offset = ^miss_addr[OFF_W-1:0];

    l1_beat_counter #(
        .COUNT (BEATS),
        .CNT_W (CNT_W)
    ) u_beat_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_end_err || w_accept),
        .i_inc    (w_beat),
        .o_cnt    (w_cnt),
        .o_last_c (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line <= '0;
        end else if (w_accept) begin
            r_line <= miss_addr[L2_ADDR_WIDTH-1:OFF_W];
        end
    end

    // Any burst end other than a clean last beat (error or short) aborts.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_REQ;
            ST_REQ:  if (req_ack)  w_next = ST_FILL;
            ST_FILL: begin
                if (w_end_ok) begin
                    w_next = ST_TAG;
                end else if (w_end_err) begin
                    w_next = ST_ERR;
                end
            end
            ST_TAG:  w_next = ST_IDLE;
            ST_ERR:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        miss_ack    = 1'b0;
        req_val     = 1'b0;
        req_size    = '0;
        ram_wen     = 1'b0;
        ram_wdata   = '0;
        tag_wr_val  = 1'b0;
        refill_done = 1'b0;
        refill_err  = 1'b0;
        case (r_state)
            ST_IDLE: miss_ack = w_accept;
            ST_REQ: begin
                req_val  = 1'b1;
                req_size = L2_SIZE_WIDTH'(OFF_W);
            end
            ST_FILL: begin
                ram_wen   = resp_rdata_val;
                ram_wdata = resp_rdata_val ? resp_rdata : '0;
            end
            ST_TAG: begin
                tag_wr_val  = 1'b1;
                refill_done = 1'b1;
            end
            ST_ERR:  refill_err = 1'b1;
            default: ;
        endcase
    end

    assign req_nc      = 1'b0;
    assign req_cmd     = L2_CMND_WIDTH'(L2_CMD_RD);
    assign req_addr    = {r_line, {OFF_W{1'b0}}};
    assign ram_waddr   = {r_line, w_cnt};
    assign tag_wr_addr = r_line;
    assign tag_wr_data = r_line;

endmodule

// File: tb/tb_l1_refill_engine.sv
// Directed bench for l1_refill_engine: transaction-level expectation queues
// checked every cycle by one monitor, plus literal spot checks per scenario.
module tb_l1_refill_engine;

    localparam int EV_NONE = -1;
    localparam int EV_ACK  = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    typedef struct {
        int          kind;
        logic [10:0] line;
    } evt_t;

    typedef struct {
        logic [13:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_val;
    logic [15:0] miss_addr;
    logic        miss_ack;
    logic        refill_done;
    logic        refill_err;
    logic        req_val;
    logic        req_ack;
    logic        req_nc;
    logic [1:0]  req_cmd;
    logic [2:0]  req_size;
    logic [15:0] req_addr;
    logic        resp_rdata_val;
    logic [31:0] resp_rdata;
    logic        resp_val;
    logic        resp_err;
    logic        ram_wen;
    logic [13:0] ram_waddr;
    logic [31:0] ram_wdata;
    logic        tag_wr_val;
    logic [10:0] tag_wr_addr;
    logic [10:0] tag_wr_data;

    int n_chk  = 0;
    int n_fail = 0;
    int n_wen  = 0;
    int n_done = 0;
    int n_errp = 0;
    logic [10:0] cur_line = '0;
    logic [10:0] last_tag = '0;
    evt_t        exp_evt[$];
    wr_t         exp_wr[$];
    logic [13:0] wr_log[$];

    always #5 clk = ~clk;

    l1_refill_engine dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .miss_val       (miss_val),
        .miss_addr      (miss_addr),
        .miss_ack       (miss_ack),
        .refill_done    (refill_done),
        .refill_err     (refill_err),
        .req_val        (req_val),
        .req_ack        (req_ack),
        .req_nc         (req_nc),
        .req_cmd        (req_cmd),
        .req_size       (req_size),
        .req_addr       (req_addr),
        .resp_rdata_val (resp_rdata_val),
        .resp_rdata     (resp_rdata),
        .resp_val       (resp_val),
        .resp_err       (resp_err),
        .ram_wen        (ram_wen),
        .ram_waddr      (ram_waddr),
        .ram_wdata      (ram_wdata),
        .tag_wr_val     (tag_wr_val),
        .tag_wr_addr    (tag_wr_addr),
        .tag_wr_data    (tag_wr_data)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic evt_t pop_evt();
        evt_t e;
        e.kind = EV_NONE;
        e.line = '0;
        if (exp_evt.size() != 0) e = exp_evt.pop_front();
        return e;
    endfunction

    // Per-cycle monitor: every DUT action must match the next expected one.
    always @(negedge clk) begin
        evt_t e;
        wr_t  w;
        check("req_nc", 64'(req_nc), 64'd0);
        if (req_val) begin
            check("req_cmd", 64'(req_cmd), 64'd0);
            check("req_size", 64'(req_size), 64'd5);
            check("req_addr_model", 64'(req_addr), 64'({cur_line, 5'b0}));
        end
        if (ram_wen) begin
            n_wen++;
            wr_log.push_back(ram_waddr);
            if (exp_wr.size() == 0) begin
                check("ram_wen_unexpected", 64'(1), 64'(0));
            end else begin
                w = exp_wr.pop_front();
                check("ram_waddr", 64'(ram_waddr), 64'(w.addr));
                check("ram_wdata", 64'(ram_wdata), 64'(w.data));
            end
        end
        if (miss_ack) begin
            e = pop_evt();
            check("ack_order", 64'(e.kind), 64'(EV_ACK));
            cur_line = e.line;
        end
        if (tag_wr_val || refill_done) begin
            n_done++;
            e = pop_evt();
            check("done_order", 64'(e.kind), 64'(EV_DONE));
            check("tag_wr_val", 64'(tag_wr_val), 64'd1);
            check("refill_done", 64'(refill_done), 64'd1);
            check("tag_wr_addr", 64'(tag_wr_addr), 64'(e.line));
            check("tag_wr_data", 64'(tag_wr_data), 64'(e.line));
            last_tag = tag_wr_addr;
        end
        if (refill_err) begin
            n_errp++;
            e = pop_evt();
            check("err_order", 64'(e.kind), 64'(EV_ERR));
            check("tag_on_err", 64'(tag_wr_val), 64'd0);
        end
    end

    task automatic wait_ack();
        bit got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            got = miss_ack;
        end
        check("miss_ack_seen", 64'(got), 64'd1);
    endtask

    task automatic do_miss(input logic [15:0] addr, input bit hold);
        evt_t e;
        e.kind = EV_ACK;
        e.line = addr[15:5];
        exp_evt.push_back(e);
        miss_addr = addr;
        miss_val  = 1'b1;
        wait_ack();
        @(posedge clk); #1;
        if (!hold) miss_val = 1'b0;
    endtask

    task automatic serve_req(input int delay, input logic [15:0] want_addr);
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            check("req_val_held", 64'(req_val), 64'd1);
            check("req_addr_held", 64'(req_addr), 64'(want_addr));
            @(posedge clk); #1;
        end
        req_ack = 1'b1;
        @(negedge clk);
        check("req_val_at_ack", 64'(req_val), 64'd1);
        check("req_addr_at_ack", 64'(req_addr), 64'(want_addr));
        @(posedge clk); #1;
        req_ack = 1'b0;
    endtask

    // A burst ending on anything but a clean 8th beat must abort the refill.
    task automatic send_beats(input logic [10:0] line, input logic [31:0] base,
                              input int n, input int gap, input bit term, input bit err);
        evt_t e;
        wr_t  w;
        for (int k = 0; k < n; k++) begin
            w.addr = {line, 3'(k)};
            w.data = base + 32'(k);
            exp_wr.push_back(w);
        end
        if (term) begin
            e.kind = (err || n != 8) ? EV_ERR : EV_DONE;
            e.line = line;
            exp_evt.push_back(e);
        end
        for (int k = 0; k < n; k++) begin
            resp_rdata_val = 1'b1;
            resp_rdata     = base + 32'(k);
            resp_val       = term && (k == n - 1);
            resp_err       = term && (k == n - 1) && err;
            if (k == 0) begin
                @(negedge clk);
                check("req_val_dropped", 64'(req_val), 64'd0);
            end
            @(posedge clk); #1;
            resp_rdata_val = 1'b0;
            resp_val       = 1'b0;
            resp_err       = 1'b0;
            resp_rdata     = '0;
            if (k < n - 1) begin
                repeat (gap) begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic drain();
        bit empty = 1'b0;
        for (int i = 0; i < 30 && !empty; i++) begin
            @(negedge clk);
            empty = (exp_evt.size() == 0) && (exp_wr.size() == 0);
        end
        check("drain_timeout", 64'(empty), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_miss_ack"}, 64'(miss_ack), 64'd0);
        check({tag, "_req_val"}, 64'(req_val), 64'd0);
        check({tag, "_req_addr"}, 64'(req_addr), 64'd0);
        check({tag, "_req_size"}, 64'(req_size), 64'd0);
        check({tag, "_ram_wen"}, 64'(ram_wen), 64'd0);
        check({tag, "_ram_waddr"}, 64'(ram_waddr), 64'd0);
        check({tag, "_ram_wdata"}, 64'(ram_wdata), 64'd0);
        check({tag, "_tag_wr_val"}, 64'(tag_wr_val), 64'd0);
        check({tag, "_tag_wr_addr"}, 64'(tag_wr_addr), 64'd0);
        check({tag, "_done"}, 64'(refill_done), 64'd0);
        check({tag, "_err"}, 64'(refill_err), 64'd0);
    endtask

    initial begin
        int base_wen;
        int base_done;
        int base_err;

        rst_n = 1'b0; miss_val = 1'b0; miss_addr = '0; req_ack = 1'b0;
        resp_rdata_val = 1'b0; resp_rdata = '0; resp_val = 1'b0; resp_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic refill, zero-wait L2.
        wr_log.delete();
        base_done = n_done;
        do_miss(16'h1234, 1'b0);
        check("basic_req_addr", 64'(req_addr), 64'h1220);
        check("basic_req_size", 64'(req_size), 64'd5);
        serve_req(0, 16'h1220);
        send_beats(11'h091, 32'hA0, 8, 0, 1'b1, 1'b0);
        drain();
        check("basic_nwrites", 64'(wr_log.size()), 64'd8);
        if (wr_log.size() == 8) begin
            check("basic_first_waddr", 64'(wr_log[0]), 64'h488);
            check("basic_last_waddr", 64'(wr_log[7]), 64'h48F);
        end
        check("basic_tag", 64'(last_tag), 64'h091);
        check("basic_done_pulses", 64'(n_done - base_done), 64'd1);

        // Stalled accept and gapped beats.
        base_wen = n_wen;
        do_miss(16'hBEEF, 1'b0);
        serve_req(4, 16'hBEE0);
        send_beats(11'h5F7, 32'h1000_0000, 8, 1, 1'b1, 1'b0);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("stall_wen_count", 64'(n_wen - base_wen), 64'd8);
        check("stall_tag", 64'(last_tag), 64'h5F7);

        // Error on beat 3, then a miss that must restart at beat 0.
        base_wen = n_wen; base_done = n_done; base_err = n_errp;
        do_miss(16'h0040, 1'b0);
        serve_req(0, 16'h0040);
        send_beats(11'h002, 32'hE0, 4, 0, 1'b1, 1'b1);
        drain();
        check("err_wen_count", 64'(n_wen - base_wen), 64'd4);
        check("err_no_tag", 64'(n_done - base_done), 64'd0);
        check("err_pulses", 64'(n_errp - base_err), 64'd1);
        wr_log.delete();
        do_miss(16'hFFFC, 1'b0);
        serve_req(0, 16'hFFE0);
        send_beats(11'h7FF, 32'hC0, 8, 0, 1'b1, 1'b0);
        drain();
        if (wr_log.size() > 0) check("after_err_first_waddr", 64'(wr_log[0]), 64'h3FF8);
        else check("after_err_writes", 64'd0, 64'd8);

        // Short burst: clean end before the last beat counts as an error.
        base_err = n_errp; base_done = n_done;
        do_miss(16'h2000, 1'b0);
        serve_req(1, 16'h2000);
        send_beats(11'h100, 32'h50, 5, 0, 1'b1, 1'b0);
        drain();
        check("short_err_pulse", 64'(n_errp - base_err), 64'd1);
        check("short_no_tag", 64'(n_done - base_done), 64'd0);

        // Back-to-back misses with miss_val held high.
        base_done = n_done;
        do_miss(16'h3000, 1'b1);
        serve_req(0, 16'h3000);
        send_beats(11'h180, 32'h300, 8, 0, 1'b1, 1'b0);
        begin
            evt_t e;
            e.kind = EV_ACK;
            e.line = 11'h181;
            exp_evt.push_back(e);
        end
        miss_addr = 16'h3020;
        wait_ack();
        check("b2b_done_before_ack2", 64'(n_done - base_done), 64'd1);
        @(posedge clk); #1;
        miss_val = 1'b0;
        serve_req(0, 16'h3020);
        send_beats(11'h181, 32'h400, 8, 0, 1'b1, 1'b0);
        drain();
        check("b2b_done_pulses", 64'(n_done - base_done), 64'd2);

        // Spurious L2 traffic in IDLE.
        base_wen = n_wen;
        for (int i = 0; i < 3; i++) begin
            resp_rdata_val = 1'b1; resp_val = 1'b1; resp_rdata = 32'hBAD0 + 32'(i);
            @(posedge clk); #1;
        end
        resp_rdata_val = 1'b0; resp_val = 1'b0; resp_rdata = '0;
        @(posedge clk); #1;
        check("idle_no_wen", 64'(n_wen - base_wen), 64'd0);

        // Reset mid-burst after beat 2.
        base_done = n_done; base_err = n_errp;
        do_miss(16'h4444, 1'b0);
        serve_req(0, 16'h4440);
        send_beats(11'h222, 32'h70, 3, 0, 1'b0, 1'b0);
        resp_rdata_val = 1'b1; resp_rdata = 32'hDEAD; miss_val = 1'b1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clk); #1;
        miss_val = 1'b0; resp_rdata_val = 1'b0; resp_rdata = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_no_done", 64'(n_done - base_done), 64'd0);
        check("midrst_no_err", 64'(n_errp - base_err), 64'd0);
        do_miss(16'h4444, 1'b0);
        serve_req(0, 16'h4440);
        send_beats(11'h222, 32'h80, 8, 0, 1'b1, 1'b0);
        drain();
        check("midrst_recover_done", 64'(n_done - base_done), 64'd1);
        check("final_evt_empty", 64'(exp_evt.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
        $finish;
    end

endmodule
